// File: rtl/tcm_sram.sv
// Parametrised single-port tightly-coupled memory with valid/ready request and response
// channels, an optional response pipeline stage, and a post-reset zero-fill sequence.
module tcm_sram #(
    parameter int ADDR_WIDTH     = 9,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_SIZE      = 8,
    parameter int OUTPUT_REG     = 0,
    parameter int CLEAR_ON_RESET = 1,
    localparam int DEPTH         = 2 ** ADDR_WIDTH,
    localparam int BE_WIDTH      = DATA_WIDTH / BYTE_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [BE_WIDTH-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done
);

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] READY = 1'b1;

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  stall;
    logic                  out_free;
    logic                  clr_we;
    logic                  wr_acc;
    logic                  rd_acc;

    assign init_done = (state == READY);
    assign req_ready = (state == READY) && !stall;
    assign out_free  = !rsp_valid || rsp_ready;
    assign clr_we    = (state == CLEAR) && !rst;
    assign wr_acc    = req_valid && req_ready && req_write;
    assign rd_acc    = req_valid && req_ready && !req_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            if (&clr_cnt) begin
                state <= READY;
            end else begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    // Array has no reset: rst only restarts the clear walk, contents otherwise persist.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (req_be[i]) begin
                    mem[req_addr][i*BYTE_SIZE +: BYTE_SIZE] <= req_wdata[i*BYTE_SIZE +: BYTE_SIZE];
                end
            end
        end
    end

    generate
        if (OUTPUT_REG != 0) begin : g_oreg
            logic                  s1_valid;
            logic [DATA_WIDTH-1:0] s1_data;

            // An empty stage 1 can still absorb one read while the output is held.
            assign stall = rsp_valid && !rsp_ready && s1_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_valid  <= 1'b0;
                    s1_data   <= '0;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= '0;
                end else begin
                    if (out_free) begin
                        rsp_valid <= s1_valid;
                        if (s1_valid) begin
                            rsp_rdata <= s1_data;
                        end
                    end
                    if (rd_acc) begin
                        s1_valid <= 1'b1;
                        s1_data  <= mem[req_addr];
                    end else if (out_free) begin
                        s1_valid <= 1'b0;
                    end
                end
            end
        end else begin : g_noreg
            assign stall = rsp_valid && !rsp_ready;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rsp_valid <= 1'b0;
                    rsp_rdata <= '0;
                end else if (rd_acc) begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= mem[req_addr];
                end else if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_tcm_sram.sv
// Directed bench for tcm_sram: default config, OUTPUT_REG=1 config, and a 9-bit-byte
// config without clear, driven from one linear sequence of steps.
module tb_tcm_sram;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // dut0: defaults
    logic        v0 = 0, w0 = 0, rr0 = 1, qr0, rv0, id0;
    logic [8:0]  a0 = '0;
    logic [31:0] d0 = '0, rd0;
    logic [3:0]  be0 = '0;
    // dut1: 16 words, OUTPUT_REG=1, clear on reset
    logic        v1 = 0, w1 = 0, rr1 = 1, qr1, rv1, id1;
    logic [3:0]  a1 = '0;
    logic [31:0] d1 = '0, rd1;
    logic [3:0]  be1 = '0;
    // dut2: 16 x 36 with 9-bit bytes, no clear
    logic        v2 = 0, w2 = 0, rr2 = 1, qr2, rv2, id2;
    logic [3:0]  a2 = '0;
    logic [35:0] d2 = '0, rd2;
    logic [3:0]  be2 = '0;

    tcm_sram dut0 (
        .clk(clk), .rst(rst), .req_valid(v0), .req_ready(qr0), .req_write(w0),
        .req_addr(a0), .req_wdata(d0), .req_be(be0), .rsp_valid(rv0),
        .rsp_ready(rr0), .rsp_rdata(rd0), .init_done(id0)
    );

    tcm_sram #(.ADDR_WIDTH(4), .OUTPUT_REG(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(qr1), .req_write(w1),
        .req_addr(a1), .req_wdata(d1), .req_be(be1), .rsp_valid(rv1),
        .rsp_ready(rr1), .rsp_rdata(rd1), .init_done(id1)
    );

    tcm_sram #(.ADDR_WIDTH(4), .DATA_WIDTH(36), .BYTE_SIZE(9), .CLEAR_ON_RESET(0)) dut2 (
        .clk(clk), .rst(rst), .req_valid(v2), .req_ready(qr2), .req_write(w2),
        .req_addr(a2), .req_wdata(d2), .req_be(be2), .rsp_valid(rv2),
        .rsp_ready(rr2), .rsp_rdata(rd2), .init_done(id2)
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bad;

        // reset values
        repeat (3) tick();
        chk("rst_req_ready0", 64'(qr0), 64'd0);
        chk("rst_rsp_valid0", 64'(rv0), 64'd0);
        chk("rst_rsp_rdata0", 64'(rd0), 64'd0);
        chk("rst_init_done0", 64'(id0), 64'd0);
        chk("rst_init_done2", 64'(id2), 64'd1);
        chk("rst_req_ready2", 64'(qr2), 64'd1);

        // clear takes 512 edges after the last reset edge
        rst = 1'b0;
        repeat (511) tick();
        chk("clear_busy", 64'({id0, qr0}), 64'd0);
        tick();
        chk("clear_done", 64'({id0, qr0}), 64'b11);

        // every word reads back zero, one read per cycle
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            v0 = 1; w0 = 0; a0 = 9'(i);
            tick();
            if (!(rv0 === 1'b1 && rd0 === 32'h0)) bad++;
        end
        v0 = 0;
        chk("clear_all_zero", 64'(bad), 64'd0);

        // byte-enable merge, read immediately after write
        v0 = 1; w0 = 1; a0 = 9'd5; d0 = 32'hDEAD_BEEF; be0 = 4'hF;
        tick();
        chk("wr_no_rsp", 64'(rv0), 64'd0);
        d0 = 32'h1122_3344; be0 = 4'b0101;
        tick();
        w0 = 0;
        tick();
        v0 = 0;
        chk("be_merge", 64'({rv0, rd0}), {31'd0, 1'b1, 32'hDE22_BE44});
        v0 = 1; w0 = 1; d0 = 32'h0; be0 = 4'b0000;
        tick();
        w0 = 0;
        tick();
        v0 = 0;
        chk("be_zero_noop", 64'({rv0, rd0}), {31'd0, 1'b1, 32'hDE22_BE44});

        // backpressure on dut0
        for (int i = 0; i < 4; i++) begin
            v0 = 1; w0 = 1; be0 = 4'hF; a0 = 9'(20 + i); d0 = 32'hA0 + 32'(i);
            tick();
        end
        w0 = 0; a0 = 9'd20;
        tick();
        chk("bp_first", 64'({rv0, rd0}), {31'd0, 1'b1, 32'hA0});
        rr0 = 0; a0 = 9'd21;
        #1;
        chk("bp_ready_low", 64'(qr0), 64'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold", 64'({rv0, qr0, rd0}), {30'd0, 2'b10, 32'hA0});
        end
        rr0 = 1;
        #1;
        chk("bp_release", 64'(qr0), 64'd1);
        tick();
        chk("bp_r21", 64'({rv0, rd0}), {31'd0, 1'b1, 32'hA1});
        a0 = 9'd22;
        tick();
        chk("bp_r22", 64'({rv0, rd0}), {31'd0, 1'b1, 32'hA2});
        a0 = 9'd23;
        tick();
        chk("bp_r23", 64'({rv0, rd0}), {31'd0, 1'b1, 32'hA3});
        v0 = 0;
        tick();
        chk("bp_drain", 64'(rv0), 64'd0);

        // OUTPUT_REG=1 stream: latency 2, no gaps, in order
        chk("oreg_init_done", 64'(id1), 64'd1);
        for (int i = 0; i < 16; i++) begin
            v1 = 1; w1 = 1; be1 = 4'hF; a1 = 4'(i); d1 = 32'(i);
            tick();
        end
        w1 = 0;
        for (int c = 0; c <= 16; c++) begin
            if (c < 16) begin
                v1 = 1; a1 = 4'(c);
            end else begin
                v1 = 0;
            end
            tick();
            if (c == 0) chk("oreg_latency", 64'(rv1), 64'd0);
            else chk("oreg_stream", 64'({rv1, qr1, rd1}), {30'd0, 2'b11, 32'(c - 1)});
        end
        tick();
        chk("oreg_end", 64'(rv1), 64'd0);

        // OUTPUT_REG=1 stall: second read parks in stage 1, then drains
        rr1 = 0; v1 = 1; a1 = 4'd3;
        tick();
        a1 = 4'd4;
        tick();
        chk("oreg_stall", 64'({rv1, qr1, rd1}), {30'd0, 2'b10, 32'd3});
        tick();
        tick();
        chk("oreg_hold", 64'({rv1, qr1, rd1}), {30'd0, 2'b10, 32'd3});
        v1 = 0; rr1 = 1;
        tick();
        chk("oreg_drain4", 64'({rv1, rd1}), {31'd0, 1'b1, 32'd4});
        tick();
        chk("oreg_empty", 64'(rv1), 64'd0);

        // reset discards pending responses
        v0 = 1; w0 = 0; a0 = 9'd22; rr0 = 0;
        v1 = 1; a1 = 4'd7; rr1 = 0;
        tick();
        v0 = 0; v1 = 0;
        tick();
        chk("pend_before_rst", 64'({rv0, rv1}), 64'b11);
        rst = 1;
        tick();
        chk("rst_drops_rsp", 64'({rv0, rv1}), 64'b00);
        rr0 = 1; rr1 = 1;

        // reset mid-clear restarts the walk from 0
        rst = 0;
        repeat (200) tick();
        chk("mid_clear_busy", 64'(id0), 64'd0);
        rst = 1;
        tick();
        rst = 0;
        repeat (511) tick();
        chk("restart_busy", 64'(id0), 64'd0);
        tick();
        chk("restart_done", 64'(id0), 64'd1);
        v0 = 1; w0 = 0; a0 = 9'd22;
        tick();
        v0 = 0;
        chk("recleared", 64'({rv0, rd0}), {31'd0, 1'b1, 32'h0});

        // 36-bit word, 9-bit bytes, top lane only
        chk("small_init_done", 64'(id2), 64'd1);
        v2 = 1; w2 = 1; a2 = 4'd15; d2 = 36'hF_FFFF_FFFF; be2 = 4'b1000;
        tick();
        w2 = 0;
        tick();
        v2 = 0;
        chk("small_top_lane", 64'({rv2, rd2 & 36'hF_F800_0000}), {27'd0, 1'b1, 36'hF_F800_0000});
        v2 = 1; w2 = 1; d2 = 36'h0; be2 = 4'b0111;
        tick();
        w2 = 0;
        tick();
        v2 = 0;
        chk("small_full", 64'({rv2, rd2}), {27'd0, 1'b1, 36'hF_F800_0000});

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
